mem_router: RTL and testbench

- Parametrised one-master/N-slave memory router, the successor to the hard-coded SoC address decoder.
- Decodes the arbiter's memory request against NSLV address windows and forwards it with the window base subtracted.
- Tracks the single outstanding transaction and returns only the selected slave's response.
- Generates a registered error response for unmapped addresses; an optional watchdog handles slaves that never respond.

---
 rtl/mem_router_pkg.sv | 37 +++
 rtl/mem_router_if.sv | 35 +++
 rtl/mem_router_dec.sv | 34 +++
 rtl/mem_router.sv | 132 +++++++++++++
 tb/tb_mem_router.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/mem_router_pkg.sv
// Shared types and default address map for the one-master/N-slave memory router.
package mem_router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ERR  = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] top;
  } slv_win_t;

  // Legacy SoC map, kept so integrators can build SLV_BASE/SLV_TOP from it
  localparam logic [31:0] ROM_BASE   = 32'h0000_0000;
  localparam logic [31:0] ROM_TOP    = 32'h0001_0000;
  localparam logic [31:0] CLINT_BASE = 32'h0200_0000;
  localparam logic [31:0] CLINT_TOP  = 32'h0201_0000;
  localparam logic [31:0] CLIC_BASE  = 32'h0280_0000;
  localparam logic [31:0] CLIC_TOP   = 32'h0281_0000;
  localparam logic [31:0] BRAM_BASE  = 32'h1000_0000;
  localparam logic [31:0] BRAM_TOP   = 32'h1001_0000;
  localparam logic [31:0] PRINT_BASE = 32'h1100_0000;
  localparam logic [31:0] PRINT_TOP  = 32'h1100_0010;

  localparam int DEF_NSLV = 5;
  localparam logic [DEF_NSLV*32-1:0] DEF_SLV_BASE =
    {PRINT_BASE, BRAM_BASE, CLIC_BASE, CLINT_BASE, ROM_BASE};
  localparam logic [DEF_NSLV*32-1:0] DEF_SLV_TOP =
    {PRINT_TOP, BRAM_TOP, CLIC_TOP, CLINT_TOP, ROM_TOP};

  function automatic logic win_hit(input slv_win_t w, input logic [31:0] addr);
    return (addr >= w.base) && (addr < w.top);
  endfunction

endpackage

// File: rtl/mem_router_if.sv
// Memory-side and slave-side bus bundle of the router; 'slave' is the router's view.
interface mem_router_if #(
  parameter int NSLV = 6
);
  logic                 memory_valid;
  logic                 memory_instr;
  logic [31:0]          memory_addr;
  logic [31:0]          memory_wdata;
  logic [3:0]           memory_wstrb;
  logic [31:0]          memory_rdata;
  logic                 memory_error;
  logic                 memory_ready;

  logic [NSLV-1:0]      slv_valid;
  logic                 slv_instr;
  logic [31:0]          slv_addr;
  logic [31:0]          slv_wdata;
  logic [3:0]           slv_wstrb;
  logic [NSLV*32-1:0]   slv_rdata;
  logic [NSLV-1:0]      slv_ready;

  modport slave (
    input  memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb,
    output memory_rdata, memory_error, memory_ready,
    output slv_valid, slv_instr, slv_addr, slv_wdata, slv_wstrb,
    input  slv_rdata, slv_ready
  );

  modport master (
    output memory_valid, memory_instr, memory_addr, memory_wdata, memory_wstrb,
    input  memory_rdata, memory_error, memory_ready,
    input  slv_valid, slv_instr, slv_addr, slv_wdata, slv_wstrb,
    output slv_rdata, slv_ready
  );
endinterface

// File: rtl/mem_router_dec.sv
// Combinational window decoder: one-hot hit plus encoded index, lowest index wins.
module mem_router_dec
  import mem_router_pkg::*;
#(
  parameter int                    NSLV     = 6,
  parameter int                    IDX_W    = 3,
  parameter logic [NSLV*32-1:0]    SLV_BASE = '0,
  parameter logic [NSLV*32-1:0]    SLV_TOP  = '0
) (
  input  logic [31:0]      addr,
  output logic [NSLV-1:0]  hit,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  slv_win_t win;

  always_comb begin
    win = '0;
    idx = '0;
    any = 1'b0;
    // Walk downward so the lowest matching index is the last one written
    for (int i = NSLV - 1; i >= 0; i--) begin
      win.base = SLV_BASE[i*32 +: 32];
      win.top  = SLV_TOP[i*32 +: 32];
      if (win_hit(win, addr)) begin
        idx = IDX_W'(i);
        any = 1'b1;
      end
    end
    hit = any ? (NSLV'(1) << idx) : '0;
  end

endmodule

// File: rtl/mem_router.sv
// One-master/N-slave memory router with single outstanding transaction.
// Optional slave watchdog enabled by defining MEM_ROUTER_TIMEOUT_EN.
module mem_router
  import mem_router_pkg::*;
#(
  parameter int                 NSLV        = 6,
  parameter logic [NSLV*32-1:0] SLV_BASE    = '0,
  parameter logic [NSLV*32-1:0] SLV_TOP     = '0,
  parameter int                 TIMEOUT_CYC = 1024
) (
  input  logic        clock,
  input  logic        reset,
  mem_router_if.slave bus,
  output logic        proto_err
);

  localparam int IDX_W = (NSLV > 1) ? $clog2(NSLV) : 1;

  if (NSLV < 1 || NSLV > 16 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("mem_router: NSLV must be 1..16 and TIMEOUT_CYC at least 1");
  end

  state_t            state, state_nxt;
  logic [IDX_W-1:0]  cur_idx, cur_idx_nxt;
  logic [NSLV-1:0]   dec_hit;
  logic [IDX_W-1:0]  dec_idx;
  logic              dec_any;
  logic              sel_ready;
  logic [31:0]       sel_rdata;
  logic              req_ok;
  logic              take;
  logic              mem_ready, mem_error;
  logic [31:0]       mem_rdata;

  mem_router_dec #(
    .NSLV     (NSLV),
    .IDX_W    (IDX_W),
    .SLV_BASE (SLV_BASE),
    .SLV_TOP  (SLV_TOP)
  ) u_dec (
    .addr (bus.memory_addr),
    .hit  (dec_hit),
    .idx  (dec_idx),
    .any  (dec_any)
  );

  assign sel_ready = bus.slv_ready[cur_idx];
  assign sel_rdata = bus.slv_rdata[cur_idx*32 +: 32];

  // A new request is accepted when idle or in the cycle the current slave completes
  assign req_ok = (state == ST_IDLE) || ((state == ST_BUSY) && sel_ready);
  assign take   = bus.memory_valid && req_ok && reset;

  assign bus.slv_valid = (take && dec_any) ? dec_hit : '0;
  assign bus.slv_addr  = bus.memory_addr - (dec_any ? SLV_BASE[dec_idx*32 +: 32] : 32'd0);
  assign bus.slv_instr = bus.memory_instr;
  assign bus.slv_wdata = bus.memory_wdata;
  assign bus.slv_wstrb = bus.memory_wstrb;

`ifdef MEM_ROUTER_TIMEOUT_EN
  logic [31:0] wdog_cnt;
  logic        wdog_expired;

  assign wdog_expired = (wdog_cnt == 32'(TIMEOUT_CYC - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wdog_cnt <= '0;
    end else if (take && dec_any) begin
      wdog_cnt <= '0;
    end else if (state == ST_BUSY) begin
      wdog_cnt <= wdog_cnt + 32'd1;
    end
  end
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      cur_idx   <= '0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      cur_idx   <= cur_idx_nxt;
      proto_err <= proto_err | (bus.memory_valid & ~req_ok);
    end
  end

  always_comb begin
    state_nxt   = state;
    cur_idx_nxt = cur_idx;
    mem_ready   = 1'b0;
    mem_error   = 1'b0;
    mem_rdata   = '0;
    case (state)
      ST_IDLE: begin
        if (bus.memory_valid) begin
          state_nxt   = dec_any ? ST_BUSY : ST_ERR;
          cur_idx_nxt = dec_any ? dec_idx : cur_idx;
        end
      end
      ST_BUSY: begin
        mem_ready = sel_ready;
        mem_rdata = sel_ready ? sel_rdata : 32'd0;
        if (sel_ready) begin
          if (bus.memory_valid) begin
            state_nxt   = dec_any ? ST_BUSY : ST_ERR;
            cur_idx_nxt = dec_any ? dec_idx : cur_idx;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
`ifdef MEM_ROUTER_TIMEOUT_EN
        else if (wdog_expired) begin
          state_nxt = ST_ERR;
        end
`endif
      end
      ST_ERR: begin
        mem_ready = 1'b1;
        mem_error = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.memory_ready = mem_ready;
  assign bus.memory_error = mem_error;
  assign bus.memory_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_router.sv
// Directed bench for mem_router: two 2-slave instances (adjacent and overlapping maps).
module tb_mem_router;
  logic clock;
  logic reset;
  logic proto_err_a, proto_err_b;
  int   checks;
  int   failures;

  mem_router_if #(.NSLV(2)) ifa();
  mem_router_if #(.NSLV(2)) ifb();

  mem_router #(
    .NSLV(2), .SLV_BASE({32'h1000, 32'h0}), .SLV_TOP({32'h2000, 32'h1000}), .TIMEOUT_CYC(8)
  ) dut_a (.clock(clock), .reset(reset), .bus(ifa), .proto_err(proto_err_a));

  mem_router #(
    .NSLV(2), .SLV_BASE({32'h1000, 32'h0}), .SLV_TOP({32'h3000, 32'h2000}), .TIMEOUT_CYC(8)
  ) dut_b (.clock(clock), .reset(reset), .bus(ifb), .proto_err(proto_err_b));

  always #5 clock = ~clock;

  task automatic idle_all();
    ifa.memory_valid = 0; ifa.memory_instr = 0; ifa.memory_addr = 0;
    ifa.memory_wdata = 0; ifa.memory_wstrb = 0; ifa.slv_rdata = 0; ifa.slv_ready = 0;
    ifb.memory_valid = 0; ifb.memory_instr = 0; ifb.memory_addr = 0;
    ifb.memory_wdata = 0; ifb.memory_wstrb = 0; ifb.slv_rdata = 0; ifb.slv_ready = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_all();
    #1 reset = 1'b0;
    #2;
    checks++; if (ifa.memory_ready !== 1'b0) begin failures++; $display("FAIL rst_ready got=%b exp=0", ifa.memory_ready); end
    checks++; if (ifa.memory_error !== 1'b0) begin failures++; $display("FAIL rst_error got=%b exp=0", ifa.memory_error); end
    checks++; if (ifa.memory_rdata !== 32'h0) begin failures++; $display("FAIL rst_rdata got=%h exp=0", ifa.memory_rdata); end
    checks++; if (ifa.slv_valid !== 2'b00) begin failures++; $display("FAIL rst_slv_valid got=%b exp=00", ifa.slv_valid); end
    checks++; if (proto_err_a !== 1'b0) begin failures++; $display("FAIL rst_proto_err got=%b exp=0", proto_err_a); end
    @(negedge clock); reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_read();
    @(negedge clock); ifa.memory_valid = 1; ifa.memory_addr = 32'h1004; #1;
    checks++; if (ifa.slv_valid !== 2'b10) begin failures++; $display("FAIL read_slv_valid got=%b exp=10", ifa.slv_valid); end
    checks++; if (ifa.slv_addr !== 32'h4) begin failures++; $display("FAIL read_slv_addr got=%h exp=4", ifa.slv_addr); end
    checks++; if (ifa.memory_ready !== 1'b0) begin failures++; $display("FAIL read_ready_early got=%b exp=0", ifa.memory_ready); end
    @(negedge clock); ifa.memory_valid = 0; #1;
    checks++; if (ifa.memory_ready !== 1'b0) begin failures++; $display("FAIL read_ready_wait got=%b exp=0", ifa.memory_ready); end
    @(negedge clock); ifa.slv_ready = 2'b10; ifa.slv_rdata = {32'hDEADBEEF, 32'h11111111}; #1;
    checks++; if (ifa.memory_ready !== 1'b1) begin failures++; $display("FAIL read_ready got=%b exp=1", ifa.memory_ready); end
    checks++; if (ifa.memory_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL read_rdata got=%h exp=deadbeef", ifa.memory_rdata); end
    checks++; if (ifa.memory_error !== 1'b0) begin failures++; $display("FAIL read_error got=%b exp=0", ifa.memory_error); end
    @(negedge clock); idle_all(); #1;
    checks++; if (ifa.memory_ready !== 1'b0) begin failures++; $display("FAIL read_ready_after got=%b exp=0", ifa.memory_ready); end
  endtask

  task automatic test_unmapped();
    @(negedge clock); ifa.memory_valid = 1; ifa.memory_addr = 32'h8000_0000;
    ifa.slv_rdata = {32'hA5A5A5A5, 32'h5A5A5A5A}; #1;
    checks++; if (ifa.slv_valid !== 2'b00) begin failures++; $display("FAIL unm_slv_valid got=%b exp=00", ifa.slv_valid); end
    checks++; if (ifa.memory_ready !== 1'b0) begin failures++; $display("FAIL unm_ready_early got=%b exp=0", ifa.memory_ready); end
    @(negedge clock); ifa.memory_valid = 0; #1;
    checks++; if (ifa.memory_ready !== 1'b1) begin failures++; $display("FAIL unm_ready got=%b exp=1", ifa.memory_ready); end
    checks++; if (ifa.memory_error !== 1'b1) begin failures++; $display("FAIL unm_error got=%b exp=1", ifa.memory_error); end
    checks++; if (ifa.memory_rdata !== 32'h0) begin failures++; $display("FAIL unm_rdata got=%h exp=0", ifa.memory_rdata); end
    @(negedge clock); #1;
    checks++; if ({ifa.memory_ready, ifa.memory_error} !== 2'b00) begin failures++; $display("FAIL unm_after got=%b exp=00", {ifa.memory_ready, ifa.memory_error}); end
    // Exclusive top edge of slave1 is unmapped
    @(negedge clock); ifa.memory_valid = 1; ifa.memory_addr = 32'h2000; #1;
    checks++; if (ifa.slv_valid !== 2'b00) begin failures++; $display("FAIL top_edge_slv_valid got=%b exp=00", ifa.slv_valid); end
    @(negedge clock); ifa.memory_valid = 0; #1;
    checks++; if (ifa.memory_error !== 1'b1) begin failures++; $display("FAIL top_edge_error got=%b exp=1", ifa.memory_error); end
    // Last word of slave0 with write broadcast
    @(negedge clock); ifa.memory_valid = 1; ifa.memory_addr = 32'h0FFC; ifa.memory_instr = 1;
    ifa.memory_wdata = 32'h12345678; ifa.memory_wstrb = 4'h3; #1;
    checks++; if (ifa.slv_valid !== 2'b01) begin failures++; $display("FAIL wr_slv_valid got=%b exp=01", ifa.slv_valid); end
    checks++; if (ifa.slv_addr !== 32'hFFC) begin failures++; $display("FAIL wr_slv_addr got=%h exp=ffc", ifa.slv_addr); end
    checks++; if ({ifa.slv_instr, ifa.slv_wstrb, ifa.slv_wdata} !== {1'b1, 4'h3, 32'h12345678}) begin
      failures++; $display("FAIL wr_bcast got=%b/%h/%h exp=1/3/12345678", ifa.slv_instr, ifa.slv_wstrb, ifa.slv_wdata); end
    @(negedge clock); idle_all(); ifa.slv_ready = 2'b01; ifa.slv_rdata = {32'h0, 32'h0000BEEF}; #1;
    checks++; if ({ifa.memory_ready, ifa.memory_rdata} !== {1'b1, 32'h0000BEEF}) begin
      failures++; $display("FAIL wr_resp got=%b/%h exp=1/0000beef", ifa.memory_ready, ifa.memory_rdata); end
    @(negedge clock); idle_all();
  endtask

  task automatic test_overlap();
    @(negedge clock); ifb.memory_valid = 1; ifb.memory_addr = 32'h1800; #1;
    checks++; if (ifb.slv_valid !== 2'b01) begin failures++; $display("FAIL ovl_slv_valid got=%b exp=01", ifb.slv_valid); end
    checks++; if (ifb.slv_addr !== 32'h1800) begin failures++; $display("FAIL ovl_slv_addr got=%h exp=1800", ifb.slv_addr); end
    @(negedge clock); ifb.memory_valid = 0; ifb.slv_ready = 2'b01; ifb.slv_rdata = {32'h77777777, 32'h0BAD0001}; #1;
    checks++; if (ifb.memory_rdata !== 32'h0BAD0001) begin failures++; $display("FAIL ovl_rdata got=%h exp=0bad0001", ifb.memory_rdata); end
    @(negedge clock); idle_all(); ifb.memory_valid = 1; ifb.memory_addr = 32'h2000; #1;
    checks++; if (ifb.slv_valid !== 2'b10) begin failures++; $display("FAIL ovl2_slv_valid got=%b exp=10", ifb.slv_valid); end
    checks++; if (ifb.slv_addr !== 32'h1000) begin failures++; $display("FAIL ovl2_slv_addr got=%h exp=1000", ifb.slv_addr); end
    @(negedge clock); ifb.memory_valid = 0; ifb.slv_ready = 2'b10; ifb.slv_rdata = {32'h77777777, 32'h0BAD0001}; #1;
    checks++; if ({ifb.memory_ready, ifb.memory_rdata} !== {1'b1, 32'h77777777}) begin
      failures++; $display("FAIL ovl2_resp got=%b/%h exp=1/77777777", ifb.memory_ready, ifb.memory_rdata); end
    @(negedge clock); idle_all();
  endtask

  task automatic test_back_to_back();
    @(negedge clock); ifa.memory_valid = 1; ifa.memory_addr = 32'h1008; #1;
    checks++; if (ifa.slv_valid !== 2'b10) begin failures++; $display("FAIL b2b_first got=%b exp=10", ifa.slv_valid); end
    @(negedge clock); ifa.memory_valid = 0;
    @(negedge clock); ifa.slv_ready = 2'b10; ifa.slv_rdata = {32'h22222222, 32'h0};
    ifa.memory_valid = 1; ifa.memory_addr = 32'h10; #1;
    checks++; if ({ifa.memory_ready, ifa.memory_rdata} !== {1'b1, 32'h22222222}) begin
      failures++; $display("FAIL b2b_resp1 got=%b/%h exp=1/22222222", ifa.memory_ready, ifa.memory_rdata); end
    checks++; if (ifa.slv_valid !== 2'b01) begin failures++; $display("FAIL b2b_second got=%b exp=01", ifa.slv_valid); end
    checks++; if (ifa.slv_addr !== 32'h10) begin failures++; $display("FAIL b2b_addr got=%h exp=10", ifa.slv_addr); end
    @(negedge clock); idle_all(); #1;
    checks++; if (ifa.memory_ready !== 1'b0) begin failures++; $display("FAIL b2b_gap got=%b exp=0", ifa.memory_ready); end
    @(negedge clock); ifa.slv_ready = 2'b01; ifa.slv_rdata = {32'h0, 32'hCAFEF00D}; #1;
    checks++; if ({ifa.memory_ready, ifa.memory_rdata} !== {1'b1, 32'hCAFEF00D}) begin
      failures++; $display("FAIL b2b_resp2 got=%b/%h exp=1/cafef00d", ifa.memory_ready, ifa.memory_rdata); end
    checks++; if (proto_err_a !== 1'b0) begin failures++; $display("FAIL b2b_no_proto got=%b exp=0", proto_err_a); end
    // Request while busy without completion is dropped and flagged
    @(negedge clock); idle_all(); ifa.memory_valid = 1; ifa.memory_addr = 32'h20; #1;
    checks++; if (ifa.slv_valid !== 2'b01) begin failures++; $display("FAIL pe_first got=%b exp=01", ifa.slv_valid); end
    @(negedge clock); ifa.memory_addr = 32'h24; #1;
    checks++; if (ifa.slv_valid !== 2'b00) begin failures++; $display("FAIL pe_dropped got=%b exp=00", ifa.slv_valid); end
    @(negedge clock); ifa.memory_valid = 0; #1;
    checks++; if (proto_err_a !== 1'b1) begin failures++; $display("FAIL pe_set got=%b exp=1", proto_err_a); end
    @(negedge clock); ifa.slv_ready = 2'b01; ifa.slv_rdata = {32'h0, 32'h33}; #1;
    checks++; if ({ifa.memory_ready, ifa.memory_rdata} !== {1'b1, 32'h33}) begin
      failures++; $display("FAIL pe_resp got=%b/%h exp=1/33", ifa.memory_ready, ifa.memory_rdata); end
    @(negedge clock); idle_all();
    @(negedge clock); #1;
    checks++; if (proto_err_a !== 1'b1) begin failures++; $display("FAIL pe_sticky got=%b exp=1", proto_err_a); end
    checks++; if (ifa.memory_ready !== 1'b0) begin failures++; $display("FAIL pe_no_extra got=%b exp=0", ifa.memory_ready); end
  endtask

  task automatic test_stray_and_reset();
    @(negedge clock); ifa.memory_valid = 1; ifa.memory_addr = 32'h1000; #1;
    checks++; if (ifa.slv_addr !== 32'h0) begin failures++; $display("FAIL stray_addr got=%h exp=0", ifa.slv_addr); end
    @(negedge clock); ifa.memory_valid = 0; ifa.slv_ready = 2'b01; ifa.slv_rdata = {32'h0, 32'h44}; #1;
    checks++; if ({ifa.memory_ready, ifa.memory_rdata} !== {1'b0, 32'h0}) begin
      failures++; $display("FAIL stray_ready got=%b/%h exp=0/0", ifa.memory_ready, ifa.memory_rdata); end
    @(negedge clock); ifa.slv_ready = 2'b10; ifa.slv_rdata = {32'h99999999, 32'h44}; #1;
    checks++; if (ifa.memory_ready !== 1'b1) begin failures++; $display("FAIL prereset_ready got=%b exp=1", ifa.memory_ready); end
    #1 reset = 1'b0; #1;
    checks++; if ({ifa.memory_ready, ifa.memory_error, ifa.memory_rdata} !== 34'h0) begin
      failures++; $display("FAIL async_rst_out got=%b/%b/%h exp=0/0/0", ifa.memory_ready, ifa.memory_error, ifa.memory_rdata); end
    checks++; if ({ifa.slv_valid, proto_err_a} !== 3'b000) begin
      failures++; $display("FAIL async_rst_ctl got=%b/%b exp=00/0", ifa.slv_valid, proto_err_a); end
    @(negedge clock); reset = 1'b1; #1;
    checks++; if (ifa.memory_ready !== 1'b0) begin failures++; $display("FAIL late_ready got=%b exp=0", ifa.memory_ready); end
    @(negedge clock); idle_all();
  endtask

  task automatic test_watchdog();
    @(negedge clock); ifa.memory_valid = 1; ifa.memory_addr = 32'h1000; #1;
    checks++; if (ifa.slv_valid !== 2'b10) begin failures++; $display("FAIL wd_req got=%b exp=10", ifa.slv_valid); end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock); idle_all(); #1;
      checks++; if (ifa.memory_ready !== 1'b0) begin failures++; $display("FAIL wd_wait_%0d got=%b exp=0", k, ifa.memory_ready); end
    end
    @(negedge clock); #1;
`ifdef MEM_ROUTER_TIMEOUT_EN
    checks++; if ({ifa.memory_ready, ifa.memory_error, ifa.memory_rdata} !== {2'b11, 32'h0}) begin
      failures++; $display("FAIL wd_timeout got=%b/%b/%h exp=1/1/0", ifa.memory_ready, ifa.memory_error, ifa.memory_rdata); end
    @(negedge clock); ifa.slv_ready = 2'b10; ifa.slv_rdata = {32'h55, 32'h0}; #1;
    checks++; if (ifa.memory_ready !== 1'b0) begin failures++; $display("FAIL wd_late got=%b exp=0", ifa.memory_ready); end
`else
    checks++; if (ifa.memory_ready !== 1'b0) begin failures++; $display("FAIL wd_still_wait got=%b exp=0", ifa.memory_ready); end
    @(negedge clock); ifa.slv_ready = 2'b10; ifa.slv_rdata = {32'h55, 32'h0}; #1;
    checks++; if ({ifa.memory_ready, ifa.memory_error, ifa.memory_rdata} !== {2'b10, 32'h55}) begin
      failures++; $display("FAIL wd_slow_resp got=%b/%b/%h exp=1/0/55", ifa.memory_ready, ifa.memory_error, ifa.memory_rdata); end
`endif
    @(negedge clock); idle_all();
  endtask

  initial begin
    clock    = 1'b0;
    checks   = 0;
    failures = 0;
    test_reset();
    test_read();
    test_unmapped();
    test_overlap();
    test_back_to_back();
    test_stray_and_reset();
    test_watchdog();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
